// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and default widths for the timer sequencer
package timer_pkg;

    localparam int TMR_W  = 4;
    localparam int TMR_PW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } tmr_state_t;

    function automatic logic is_active(input tmr_state_t s);
        return (s == RUN) || (s == PAUSE);
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - clock-enable divider counting 0..pre, tick on the wrap cycle
module timer_prescaler #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    input  logic [PW-1:0] pre,
    output logic          tick
);

    logic [PW-1:0] cnt;

    // clr wins so a restart on the same edge never reports a stale tick
    assign tick = en && !clr && (cnt == pre);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == pre) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_sequencer.sv
// rtl/timer_sequencer.sv - down-counting timer FSM with prescaler, one-shot and auto-reload modes
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int W  = TMR_W,
    parameter int PW = TMR_PW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    input  logic          periodic,
    input  logic [W-1:0]  load_val,
    input  logic [PW-1:0] prescale,
    output logic [W-1:0]  count,
    output logic          busy,
    output logic          done,
    output logic          expire,
    output logic          err
);

    localparam logic [W-1:0] ONE = W'(1);

    tmr_state_t    state_q, state_d;
    logic [W-1:0]  count_q, count_d;
    logic [W-1:0]  load_q, load_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          per_q, per_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          expire_q, expire_d;
    logic          err_q, err_d;

    logic start_ok;
    logic presc_en;
    logic presc_clr;
    logic tick;

    assign start_ok = start && (load_val != '0);

    // A rejected start (load 0) also freezes the prescaler so nothing moves that cycle;
    // leaving PAUSE with pause low counts as a normal RUN cycle.
    assign presc_en  = !stop && !start && is_active(state_q) && !pause;
    assign presc_clr = stop || start_ok;

    timer_prescaler #(
        .PW (PW)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (presc_en),
        .clr   (presc_clr),
        .pre   (pre_q),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        load_d   = load_q;
        pre_d    = pre_q;
        per_d    = per_q;
        expire_d = 1'b0;
        err_d    = 1'b0;

        if (stop) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start) begin
            if (start_ok) begin
                load_d  = load_val;
                pre_d   = prescale;
                per_d   = periodic;
                count_d = load_val;
                state_d = RUN;
            end else begin
                err_d = 1'b1;
            end
        end else if (is_active(state_q)) begin
            if (pause) begin
                state_d = PAUSE;
            end else begin
                state_d = RUN;
                if (tick) begin
                    if (count_q > ONE) begin
                        count_d = count_q - ONE;
                    end else begin
                        expire_d = 1'b1;
                        if (per_q) begin
                            count_d = load_q;
                        end else begin
                            count_d = '0;
                            state_d = DONE;
                        end
                    end
                end
            end
        end

        busy_d = is_active(state_d);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            load_q   <= '0;
            pre_q    <= '0;
            per_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            expire_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            load_q   <= load_d;
            pre_q    <= pre_d;
            per_q    <= per_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            expire_q <= expire_d;
            err_q    <= err_d;
        end
    end

    assign count  = count_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign expire = expire_q;
    assign err    = err_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// tb/tb_timer_sequencer.sv - directed vectors with hand-computed expectations for timer_sequencer
module tb_timer_sequencer;

    localparam int W  = 4;
    localparam int PW = 4;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          start    = 1'b0;
    logic          stop     = 1'b0;
    logic          pause    = 1'b0;
    logic          periodic = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic [PW-1:0] prescale = '0;
    logic [W-1:0]  count;
    logic          busy;
    logic          done;
    logic          expire;
    logic          err;

    int vectors     = 0;
    int miscompares = 0;

    timer_sequencer #(
        .W  (W),
        .PW (PW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .periodic (periodic),
        .load_val (load_val),
        .prescale (prescale),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .expire   (expire),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [W-1:0] lv, input logic [PW-1:0] pv, input logic per);
        load_val = lv;
        prescale = pv;
        periodic = per;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    initial begin
        int exp3[8];
        exp3 = '{4, 3, 3, 3, 3, 2, 1, 0};

        step();
        step();
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_expire", expire, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        step();

        // one-shot, load 3, prescale 0
        go(4'd3, 4'd0, 1'b0);
        chk("os_cnt0", count, 3);
        chk("os_busy0", busy, 1);
        step();
        chk("os_cnt1", count, 2);
        chk("os_exp1", expire, 0);
        step();
        chk("os_cnt2", count, 1);
        chk("os_exp2", expire, 0);
        step();
        chk("os_exp3", expire, 1);
        chk("os_cnt3", count, 0);
        chk("os_done3", done, 1);
        chk("os_busy3", busy, 0);
        step();
        chk("os_exp4", expire, 0);
        chk("os_done4", done, 1);

        // periodic, load 2, prescale 1: expire every 4 clocks
        go(4'd2, 4'd1, 1'b1);
        chk("per_cnt0", count, 2);
        chk("per_done0", done, 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("per_cnt", count, (((k % 4) == 2) || ((k % 4) == 3)) ? 1 : 2);
            chk("per_exp", expire, ((k % 4) == 0) ? 1 : 0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_cnt", count, 0);
        chk("stop_busy", busy, 0);

        // prescale all-ones: period of 16 clocks with load 1
        go(4'd1, 4'hF, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            step();
            chk("pmax_exp", expire, ((k == 16) || (k == 32)) ? 1 : 0);
            chk("pmax_cnt", count, 1);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;

        // pause for three cycles at count 3
        go(4'd5, 4'd0, 1'b0);
        chk("pz_cnt0", count, 5);
        for (int k = 1; k <= 8; k++) begin
            pause = (k >= 3) && (k <= 5);
            step();
            chk("pz_cnt", count, exp3[k-1]);
            chk("pz_exp", expire, (k == 8) ? 1 : 0);
            chk("pz_busy", busy, (k < 8) ? 1 : 0);
        end
        pause = 1'b0;

        // stop and start on the same edge: stop wins
        go(4'd4, 4'd0, 1'b0);
        chk("ss_cnt0", count, 4);
        step();
        chk("ss_cnt1", count, 3);
        stop  = 1'b1;
        start = 1'b1;
        step();
        stop  = 1'b0;
        start = 1'b0;
        chk("ss_cnt", count, 0);
        chk("ss_busy", busy, 0);
        chk("ss_exp", expire, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ss_idle_exp", expire, 0);
            chk("ss_idle_busy", busy, 0);
        end

        // start and pause on the same edge from IDLE: start wins
        pause = 1'b1;
        go(4'd2, 4'd0, 1'b0);
        chk("sp_busy", busy, 1);
        chk("sp_cnt", count, 2);
        step();
        chk("sp_held", count, 2);
        pause = 1'b0;
        step();
        chk("sp_resume", count, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // start with load 0 is rejected
        go(4'd0, 4'd0, 1'b0);
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_cnt", count, 0);
        step();
        chk("err_clear", err, 0);
        chk("err_idle", busy, 0);

        // asynchronous reset in the middle of a run
        go(4'd3, 4'd0, 1'b0);
        step();
        chk("ar_cnt_before", count, 2);
        #2 reset = 1'b1;
        #1;
        chk("ar_cnt", count, 0);
        chk("ar_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("ar_no_exp", expire, 0);
            chk("ar_cnt_idle", count, 0);
        end

        // restart at count 1 discards the old run
        go(4'd2, 4'd0, 1'b0);
        step();
        chk("rs_cnt1", count, 1);
        go(4'd4, 4'd0, 1'b0);
        chk("rs_cnt4", count, 4);
        chk("rs_no_exp", expire, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("rs_cnt", count, 4 - k);
            chk("rs_exp", expire, (k == 4) ? 1 : 0);
        end
        chk("rs_done", done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
